// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller. It latches IRQ rising edges, picks the lowest
// enabled pending line, and steps the core through stall, jump, service and return.
module interrupt_controller #(
  parameter int          ADDRESS_BITS   = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          NUM_IRQ        = 8,
  parameter logic [31:0] BASE_ADDRESS   = 32'h0000_2000,
  parameter logic [31:0] VECTOR_DEFAULT = 32'h0000_0100
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IRQ-1:0]      irq_in,
  input  logic [ADDRESS_BITS-1:0] current_pc,
  input  logic                    bus_read,
  input  logic                    bus_write,
  input  logic [ADDRESS_BITS-1:0] bus_address,
  input  logic [DATA_WIDTH-1:0]   bus_data_in,
  output logic [DATA_WIDTH-1:0]   bus_data_out,
  output logic                    bus_read_valid,
  output logic                    interrupt_stall,
  output logic                    interrupt_jump,
  output logic                    interrupt_execute,
  output logic                    interrupt_done,
  output logic [ADDRESS_BITS-1:0] saved_PC
);

  localparam logic [ADDRESS_BITS-1:0] ADDR_ENABLE  = ADDRESS_BITS'(BASE_ADDRESS);
  localparam logic [ADDRESS_BITS-1:0] ADDR_PENDING = ADDRESS_BITS'(BASE_ADDRESS + 32'h4);
  localparam logic [ADDRESS_BITS-1:0] ADDR_VECTOR  = ADDRESS_BITS'(BASE_ADDRESS + 32'h8);
  localparam logic [ADDRESS_BITS-1:0] ADDR_EOI     = ADDRESS_BITS'(BASE_ADDRESS + 32'hC);
  localparam logic [ADDRESS_BITS-1:0] ADDR_CAUSE   = ADDRESS_BITS'(BASE_ADDRESS + 32'h10);

  typedef enum logic [2:0] {
    S_IDLE, S_STALL, S_JUMP, S_SERVICE, S_RETURN
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_IRQ-1:0]      enable_q, enable_d;
  logic [NUM_IRQ-1:0]      pending_q, pending_d;
  logic [NUM_IRQ-1:0]      irq_prev_q;
  logic [ADDRESS_BITS-1:0] vector_q, vector_d;
  logic [ADDRESS_BITS-1:0] return_pc_q, return_pc_d;
  logic [ADDRESS_BITS-1:0] saved_pc_q, saved_pc_d;
  logic [4:0]              id_q, id_d;
  logic [4:0]              cause_q, cause_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;

  logic [NUM_IRQ-1:0]      rise_s;
  logic [NUM_IRQ-1:0]      svc_clr_s;
  logic [NUM_IRQ-1:0]      wr_irq_s;
  logic [NUM_IRQ-1:0]      ready_s;
  logic [ADDRESS_BITS-1:0] wr_vector_s;
  logic                    sel_enable_s, sel_pending_s, sel_vector_s, sel_eoi_s, sel_cause_s;

  function automatic logic [4:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    lowest_set = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

  assign sel_enable_s  = (bus_address == ADDR_ENABLE);
  assign sel_pending_s = (bus_address == ADDR_PENDING);
  assign sel_vector_s  = (bus_address == ADDR_VECTOR);
  assign sel_eoi_s     = (bus_address == ADDR_EOI);
  assign sel_cause_s   = (bus_address == ADDR_CAUSE);

  assign rise_s      = irq_in & ~irq_prev_q;
  assign ready_s     = pending_q & enable_q;
  assign wr_irq_s    = NUM_IRQ'(bus_data_in);
  assign wr_vector_s = ADDRESS_BITS'(bus_data_in) & ~ADDRESS_BITS'(2'b11);

  assign enable_d = (bus_write && sel_enable_s) ? wr_irq_s : enable_q;
  assign vector_d = (bus_write && sel_vector_s) ? wr_vector_s : vector_q;

  // Pending update: clears first, then new edges, so a same-cycle edge beats W1C.
  always_comb begin
    pending_d = pending_q & ~svc_clr_s;
    if (bus_write && sel_pending_s) begin
      pending_d = pending_d & ~wr_irq_s;
    end else begin
      pending_d = pending_d;
    end
    pending_d = pending_d | rise_s;
  end

  // Register read port, one cycle of latency.
  always_comb begin
    rdata_d  = '0;
    rvalid_d = 1'b0;
    if (bus_read) begin
      rvalid_d = 1'b1;
      if (sel_enable_s)       rdata_d = DATA_WIDTH'(enable_q);
      else if (sel_pending_s) rdata_d = DATA_WIDTH'(pending_q);
      else if (sel_vector_s)  rdata_d = DATA_WIDTH'(vector_q);
      else if (sel_cause_s)   rdata_d = DATA_WIDTH'(cause_q);
      else                    rdata_d = '0;
    end else begin
      rvalid_d = 1'b0;
    end
  end

  // Handler sequencing FSM: next state and the registers loaded on each transition.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    cause_d     = cause_q;
    return_pc_d = return_pc_q;
    saved_pc_d  = saved_pc_q;
    svc_clr_s   = '0;
    case (state_q)
      S_IDLE: begin
        if (|ready_s) begin
          id_d    = lowest_set(ready_s);
          state_d = S_STALL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STALL: begin
        return_pc_d = current_pc;
        svc_clr_s   = NUM_IRQ'(1) << id_q;
        cause_d     = id_q;
        saved_pc_d  = vector_q + (ADDRESS_BITS'(id_q) << 2);
        state_d     = S_JUMP;
      end
      S_JUMP: state_d = S_SERVICE;
      S_SERVICE: begin
        if (bus_write && sel_eoi_s) begin
          saved_pc_d = return_pc_q;
          state_d    = S_RETURN;
        end else begin
          state_d = S_SERVICE;
        end
      end
      S_RETURN: begin
        saved_pc_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register file, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      enable_q    <= '0;
      pending_q   <= '0;
      irq_prev_q  <= '0;
      vector_q    <= ADDRESS_BITS'(VECTOR_DEFAULT);
      return_pc_q <= '0;
      saved_pc_q  <= '0;
      id_q        <= 5'd0;
      cause_q     <= 5'd0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      irq_prev_q  <= irq_in;
      vector_q    <= vector_d;
      return_pc_q <= return_pc_d;
      saved_pc_q  <= saved_pc_d;
      id_q        <= id_d;
      cause_q     <= cause_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign interrupt_stall   = (state_q == S_STALL) || (state_q == S_JUMP);
  assign interrupt_jump    = (state_q == S_JUMP) || (state_q == S_RETURN);
  assign interrupt_execute = (state_q == S_SERVICE);
  assign interrupt_done    = (state_q == S_RETURN);
  assign saved_PC          = saved_pc_q;
  assign bus_data_out      = rdata_q;
  assign bus_read_valid    = rvalid_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sits directly upstream of the single-cycle core and drives its interrupt_stall, interrupt_jump, interrupt_execute, interrupt_done and saved_PC inputs.
- Edge-detects external IRQ lines and latches them as pending bits. Selects the lowest-index enabled pending IRQ and sequences the core into its handler and back.
- Exposes a small memory-mapped register file: enable mask, pending, vector base, end-of-interrupt (EOI), cause.

Parameters:
- ADDRESS_BITS, 32, PC and bus address width.
- DATA_WIDTH, 32, bus data width.
- NUM_IRQ, 8, number of IRQ lines (1..32).
- BASE_ADDRESS, 32'h0000_2000, register block base.
- VECTOR_DEFAULT, 32'h0000_0100, reset value of VECTOR_BASE.

Ports:
- clock  input  1  core clock.
- reset  input  1  synchronous, active-low reset.
- irq_in  input  NUM_IRQ  level IRQ lines, synchronous to clock.
- current_pc  input  ADDRESS_BITS  core fetch PC; used as the return address.
- bus_read  input  1  register read strobe.
- bus_write  input  1  register write strobe.
- bus_address  input  ADDRESS_BITS  register address.
- bus_data_in  input  DATA_WIDTH  write data.
- bus_data_out  output  DATA_WIDTH  read data.
- bus_read_valid  output  1  read data valid.
- interrupt_stall  output  1  core must hold PC this cycle.
- interrupt_jump  output  1  core must load saved_PC as next PC.
- interrupt_execute  output  1  handler in progress.
- interrupt_done  output  1  handler return cycle.
- saved_PC  output  ADDRESS_BITS  jump target: vector on entry, return PC on exit.

Behaviour:
- Reset (reset==0 at posedge):
  - State = IDLE.
  - ENABLE = 0, PENDING = 0, CAUSE = 0, VECTOR_BASE = VECTOR_DEFAULT, return_pc = 0, irq_prev = 0.
  - All outputs 0.
  - Reset mid-handler abandons the handler with no done pulse.
- Edge detect:
  - irq_prev <= irq_in every cycle.
  - A rising edge (irq_in & ~irq_prev) sets the PENDING bit.
  - A set and a W1C clear on the same bit in the same cycle: set wins.
- Register map (offsets from BASE_ADDRESS; bits above NUM_IRQ read 0):
  - +0x0 ENABLE, RW.
  - +0x4 PENDING, read; write-1-to-clear.
  - +0x8 VECTOR_BASE, RW; bits [1:0] forced to 0.
  - +0xC EOI, write-only; any write; reads 0.
  - +0x10 CAUSE, read-only; IRQ id of the last serviced interrupt.
- Bus reads:
  - One-cycle latency: bus_read at cycle N gives bus_data_out and bus_read_valid=1 at cycle N+1.
  - Unmapped address reads 0 with valid=1.
  - Otherwise bus_data_out = 0 and bus_read_valid = 0.
- Outputs are Moore-decoded from the state register. saved_PC is registered.
- FSM:
  - IDLE: if (PENDING & ENABLE) != 0, latch id = lowest set index and go to STALL.
  - STALL (1 cycle):
    - interrupt_stall=1.
    - On exit: return_pc <= current_pc, PENDING[id] <= 0, CAUSE <= id, saved_PC <= VECTOR_BASE + (id << 2).
    - Go to JUMP.
  - JUMP (1 cycle): interrupt_jump=1, interrupt_stall=1. Go to SERVICE.
  - SERVICE:
    - interrupt_execute=1.
    - No nesting; new edges accumulate in PENDING.
    - An EOI write loads saved_PC <= return_pc and goes to RETURN.
  - RETURN (1 cycle): interrupt_done=1, interrupt_jump=1. Go to IDLE.
- Earliest re-entry is the cycle after RETURN. IDLE-to-JUMP latency is 2 cycles.
- EOI writes outside SERVICE are ignored.
- A disabled pending IRQ stays pending until it is enabled or cleared.
- Vector arithmetic is modulo 2^ADDRESS_BITS.

Test Plan:
- Reset with ENABLE=0x01, VECTOR_BASE=0x100; raise irq_in[0] while current_pc=0x40:
  - stall=1 for 2 cycles.
  - jump=1 with saved_PC=0x100.
  - execute=1 afterwards.
  - CAUSE reads 0.
- In SERVICE, write EOI: the next cycle has done=1, jump=1, saved_PC=0x40, then IDLE with all outputs 0.
- ENABLE=0xFF; raise irq_in[5] and irq_in[2] on the same cycle:
  - IRQ2 serviced first, saved_PC=0x108.
  - After EOI, IRQ5 enters with saved_PC=0x114 one cycle after RETURN.
- Hold irq_in[3] high for 10 cycles with ENABLE=0: PENDING reads 0x08 exactly once per edge. Write 0x08 to PENDING: reads 0x00.
- W1C of PENDING bit 1 on the same cycle as an irq_in[1] rising edge: PENDING[1] reads 1.
- Assert reset low during SERVICE: the next cycle has all outputs 0, ENABLE=0, VECTOR_BASE=0x100, and no done pulse.
